// File: rtl/can_reg_access_arbiter.sv
// can_reg_access_arbiter: two-requester arbiter/sequencer for the CAN register-access path.
// Requester 0 = host bus interface, requester 1 = test/debug port.
// Sequence per access: IDLE -> GRANT -> (WAIT x RD_LAT for reads) -> DONE -> RELEASE.
// Optional build macro CAN_ARB_FIXED_PRIO_EN: requester 0 always wins simultaneous requests
// (default build without it: round-robin between the two requesters).
// All outputs are registered from next-state values so they line up with the state they belong to.
module can_reg_access_arbiter #(
    parameter int unsigned NUM_REGS = 31,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset,
    input  logic [1:0]            i_req,
    input  logic [1:0]            i_we,
    input  logic [2*ADDR_W-1:0]   i_addr,
    input  logic [2*DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]     i_rdata,
    output logic                  o_cs,
    output logic                  o_r_neg_w,
    output logic [NUM_REGS-1:0]   o_rs_vector,
    output logic [DATA_W-1:0]     o_wdata,
    output logic [1:0]            o_ack,
    output logic [DATA_W-1:0]     o_rdata,
    output logic                  o_err,
    output logic                  o_busy
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DONE    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic                r_owner;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_win;
    logic [ADDR_W-1:0]   w_win_addr;
    logic                w_win_we;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_bad;
    logic                w_bad;

    logic                w_nxt_cs;
    logic                w_nxt_rnw;
    logic [NUM_REGS-1:0] w_nxt_rs;
    logic [DATA_W-1:0]   w_nxt_wdata;
    logic [1:0]          w_nxt_ack;
    logic [DATA_W-1:0]   w_nxt_rdata;
    logic                w_nxt_err;
    logic                w_nxt_busy;

`ifdef CAN_ARB_FIXED_PRIO_EN
    // Fixed priority: no fairness pointer exists in this build.
`else
    logic                r_ptr;

    // Round-robin pointer: after each completed access the other requester gets priority.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_ptr <= ~r_owner;
        end
    end
`endif

    // Winner selection and the winner's request fields.
    always_comb begin
`ifdef CAN_ARB_FIXED_PRIO_EN
        w_win = i_req[0] ? 1'b0 : 1'b1;
`else
        w_win = (i_req == 2'b11) ? r_ptr : i_req[1];
`endif
        w_win_addr  = w_win ? i_addr[2*ADDR_W-1:ADDR_W]   : i_addr[ADDR_W-1:0];
        w_win_wdata = w_win ? i_wdata[2*DATA_W-1:DATA_W] : i_wdata[DATA_W-1:0];
        w_win_we    = w_win ? i_we[1] : i_we[0];
        w_win_bad   = (32'(w_win_addr) >= 32'(NUM_REGS));
        w_bad       = (32'(r_addr) >= 32'(NUM_REGS));
    end

    // Next-state and next-output decode.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cs    = 1'b0;
        w_nxt_rnw   = 1'b0;
        w_nxt_rs    = '0;
        w_nxt_wdata = o_wdata;
        w_nxt_ack   = 2'b00;
        w_nxt_rdata = o_rdata;
        w_nxt_err   = o_err;
        w_nxt_busy  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|i_req) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_cs    = 1'b1;
                    w_nxt_rnw   = ~w_win_we;
                    w_nxt_wdata = w_win_wdata;
                    w_nxt_rs    = w_win_bad ? '0 : (NUM_REGS'(1) << w_win_addr);
                    w_nxt_busy  = 1'b1;
                end
            end
            ST_GRANT: begin
                w_nxt_cs   = 1'b1;
                w_nxt_rnw  = ~r_we;
                w_nxt_busy = 1'b1;
                if (r_we) begin
                    w_nxt_state        = ST_DONE;
                    w_nxt_ack[r_owner] = 1'b1;
                    w_nxt_rdata        = '0;
                    w_nxt_err          = w_bad;
                end else begin
                    w_nxt_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_nxt_cs   = 1'b1;
                w_nxt_rnw  = 1'b1;
                w_nxt_busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_nxt_state        = ST_DONE;
                    w_nxt_ack[r_owner] = 1'b1;
                    w_nxt_rdata        = w_bad ? '0 : i_rdata;
                    w_nxt_err          = w_bad;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_RELEASE;
                w_nxt_busy  = 1'b1;
            end
            ST_RELEASE: begin
                w_nxt_state = ST_IDLE;
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            o_cs        <= 1'b0;
            o_r_neg_w   <= 1'b0;
            o_rs_vector <= '0;
            o_wdata     <= '0;
            o_ack       <= 2'b00;
            o_rdata     <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            o_cs        <= w_nxt_cs;
            o_r_neg_w   <= w_nxt_rnw;
            o_rs_vector <= w_nxt_rs;
            o_wdata     <= w_nxt_wdata;
            o_ack       <= w_nxt_ack;
            o_rdata     <= w_nxt_rdata;
            o_err       <= w_nxt_err;
            o_busy      <= w_nxt_busy;
        end
    end

    // Latch the granted request and run the read-latency counter.
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_addr  <= w_win_addr;
                        r_we    <= w_win_we;
                        r_owner <= w_win;
                    end
                end
                ST_GRANT: r_cnt <= CNT_W'(RD_LAT);
                ST_WAIT:  r_cnt <= r_cnt - CNT_W'(1);
                default:  r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_can_reg_access_arbiter.sv
// Directed bench for can_reg_access_arbiter (RD_LAT=2); inputs driven and outputs sampled on falling edges.
module tb_can_reg_access_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  i_req;
    logic [1:0]  i_we;
    logic [9:0]  i_addr;
    logic [15:0] i_wdata;
    logic [7:0]  i_rdata;
    logic        o_cs;
    logic        o_r_neg_w;
    logic [30:0] o_rs_vector;
    logic [7:0]  o_wdata;
    logic [1:0]  o_ack;
    logic [7:0]  o_rdata;
    logic        o_err;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    can_reg_access_arbiter #(
        .NUM_REGS(31), .ADDR_W(5), .DATA_W(8), .RD_LAT(2)
    ) dut (
        .i_sys_clk   (clk),
        .i_reset     (rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_rdata     (i_rdata),
        .o_cs        (o_cs),
        .o_r_neg_w   (o_r_neg_w),
        .o_rs_vector (o_rs_vector),
        .o_wdata     (o_wdata),
        .o_ack       (o_ack),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [1:0] exp_order [6];
    int         n_ack;
    int         n_cyc;

    initial begin
`ifdef CAN_ARB_FIXED_PRIO_EN
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst = 1'b1; i_req = '0; i_we = '0; i_addr = '0; i_wdata = '0; i_rdata = '0;
        cyc(); cyc();
        chk("rst_cs",   32'(o_cs), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_ack",  32'(o_ack), 0);
        chk("rst_rs",   32'(o_rs_vector), 0);
        chk("rst_rnw",  32'(o_r_neg_w), 0);
        rst = 1'b0;

        // req0 write addr 5, data A5
        i_req = 2'b01; i_we = 2'b01; i_addr = {5'd0, 5'd5}; i_wdata = {8'h00, 8'hA5};
        cyc();
        chk("t1_cs",    32'(o_cs), 1);
        chk("t1_rnw",   32'(o_r_neg_w), 0);
        chk("t1_rs",    32'(o_rs_vector), 32'h0000_0020);
        chk("t1_wdata", 32'(o_wdata), 32'hA5);
        chk("t1_noack", 32'(o_ack), 0);
        cyc();
        chk("t1_ack",   32'(o_ack), 32'b01);
        chk("t1_err",   32'(o_err), 0);
        chk("t1_rs0",   32'(o_rs_vector), 0);
        i_req = 2'b00;
        cyc();
        chk("t1_rel_cs",   32'(o_cs), 0);
        chk("t1_rel_ack",  32'(o_ack), 0);
        chk("t1_rel_busy", 32'(o_busy), 1);
        cyc();
        chk("t1_idle_busy", 32'(o_busy), 0);

        // req1 read addr 30, read latency 2
        i_req = 2'b10; i_we = 2'b00; i_addr = {5'd30, 5'd0}; i_rdata = 8'h3C;
        cyc();
        chk("t2_rs",   32'(o_rs_vector), 32'h4000_0000);
        chk("t2_rnw",  32'(o_r_neg_w), 1);
        chk("t2_cs",   32'(o_cs), 1);
        cyc();
        chk("t2_w1_rs",  32'(o_rs_vector), 0);
        chk("t2_w1_ack", 32'(o_ack), 0);
        chk("t2_w1_cs",  32'(o_cs), 1);
        cyc();
        chk("t2_w2_ack", 32'(o_ack), 0);
        cyc();
        chk("t2_ack",   32'(o_ack), 32'b10);
        chk("t2_rdata", 32'(o_rdata), 32'h3C);
        chk("t2_err",   32'(o_err), 0);
        i_req = 2'b00;
        cyc(); cyc();
        chk("t2_idle_busy", 32'(o_busy), 0);

        // both requesters held, six write transactions
        i_req = 2'b11; i_we = 2'b11; i_addr = {5'd2, 5'd1}; i_wdata = {8'h22, 8'h11};
        n_ack = 0; n_cyc = 0;
        while (n_ack < 6 && n_cyc < 60) begin
            cyc();
            n_cyc++;
            if (o_ack != 2'b00) begin
                chk($sformatf("t3_order%0d", n_ack), 32'(o_ack), 32'(exp_order[n_ack]));
                if (n_ack == 5) i_req = 2'b00;
                n_ack++;
            end
        end
        chk("t3_count", 32'(n_ack), 6);
        i_req = 2'b00;
        cyc(); cyc();

        // req0 read of illegal address 31
        i_req = 2'b01; i_we = 2'b00; i_addr = {5'd0, 5'd31}; i_rdata = 8'h77;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("t4_rs%0d", i), 32'(o_rs_vector), 0);
            if (i < 4) chk($sformatf("t4_noack%0d", i), 32'(o_ack), 0);
        end
        chk("t4_ack",   32'(o_ack), 32'b01);
        chk("t4_err",   32'(o_err), 1);
        chk("t4_rdata", 32'(o_rdata), 0);
        chk("t4_cs",    32'(o_cs), 1);
        i_req = 2'b00;
        cyc(); cyc();

        // reset during WAIT of a req0 read, req1 write pending
        i_req = 2'b01; i_we = 2'b00; i_addr = {5'd7, 5'd3}; i_wdata = {8'h5A, 8'h00};
        cyc();
        chk("t5_rs", 32'(o_rs_vector), 32'h8);
        cyc();
        chk("t5_wait_busy", 32'(o_busy), 1);
        i_req = 2'b10; i_we = 2'b10;
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_cs",    32'(o_cs), 0);
        chk("t5_rst_busy",  32'(o_busy), 0);
        chk("t5_rst_ack",   32'(o_ack), 0);
        chk("t5_rst_err",   32'(o_err), 0);
        chk("t5_rst_rdata", 32'(o_rdata), 0);
        chk("t5_rst_rnw",   32'(o_r_neg_w), 0);
        cyc();
        chk("t5_rst_ack2", 32'(o_ack), 0);
        rst = 1'b0;
        cyc();
        chk("t5_r1_rs",    32'(o_rs_vector), 32'h80);
        chk("t5_r1_wdata", 32'(o_wdata), 32'h5A);
        chk("t5_r1_rnw",   32'(o_r_neg_w), 0);
        cyc();
        chk("t5_r1_ack",   32'(o_ack), 32'b10);
        i_req = 2'b00;
        cyc(); cyc();

        // req0 write, request dropped and address changed during GRANT
        i_req = 2'b01; i_we = 2'b01; i_addr = {5'd7, 5'd0}; i_wdata = {8'h5A, 8'h11};
        cyc();
        chk("t6_rs",    32'(o_rs_vector), 32'h1);
        chk("t6_wdata", 32'(o_wdata), 32'h11);
        i_req = 2'b00; i_addr = {5'd7, 5'd9};
        cyc();
        chk("t6_ack",   32'(o_ack), 32'b01);
        chk("t6_err",   32'(o_err), 0);
        chk("t6_rdata", 32'(o_rdata), 0);
        cyc();
        chk("t6_rel_cs",  32'(o_cs), 0);
        chk("t6_rel_ack", 32'(o_ack), 0);
        cyc();
        chk("t6_idle_busy", 32'(o_busy), 0);
        cyc();
        chk("t6_stay_busy", 32'(o_busy), 0);
        chk("t6_stay_cs",   32'(o_cs), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/can_reg_access_arbiter.md
Name: can_reg_access_arbiter

Overview:
Two-requester arbiter and sequencer for the CAN controller register-access path. Requester 0 is the microcontroller bus interface; requester 1 is the internal test/debug port. The block serialises their accesses and generates the chip-select, read/write strobe and address for the register file. It also drives a single-cycle one-hot register-select vector, captures read data after a fixed latency and returns a one-cycle acknowledge to the winning requester.

Parameters:
NUM_REGS, 31, number of addressable registers; select vector width; legal addresses 0..NUM_REGS-1
ADDR_W, 5, address width per requester
DATA_W, 8, register data width
RD_LAT, 1, cycles from select pulse to valid i_rdata; legal range 1..4

Ports:
i_sys_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous active-high reset
i_req  in  2  access request per requester; held until ack
i_we  in  2  per requester: 1 = write, 0 = read
i_addr  in  2*ADDR_W  per-requester address; requester n at bits [n*ADDR_W +: ADDR_W]
i_wdata  in  2*DATA_W  per-requester write data, same packing
i_rdata  in  DATA_W  read data from register file
o_cs  out  1  register file chip select
o_r_neg_w  out  1  1 = read, 0 = write; valid while o_cs=1
o_rs_vector  out  NUM_REGS  one-hot register select, one-cycle pulse
o_wdata  out  DATA_W  latched write data of the granted access
o_ack  out  2  one-cycle acknowledge per requester
o_rdata  out  DATA_W  captured read data; valid in the ack cycle
o_err  out  1  address >= NUM_REGS; valid in the ack cycle
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - State = IDLE and round-robin pointer = 0.
  - All outputs 0, o_r_neg_w = 0, internal latches 0.
  - Reset mid-transaction aborts it; no ack is issued.
- FSM states: IDLE, GRANT, WAIT, DONE, RELEASE.
- IDLE:
  - If any i_req bit is set, select a winner and latch its addr, we and wdata plus the owner index; go to GRANT.
  - Selection: if both request, the requester equal to the pointer wins; otherwise the sole requester wins.
  - If no request, stay in IDLE.
- GRANT (1 cycle):
  - o_cs=1, o_r_neg_w=~we, o_wdata=latched data.
  - o_rs_vector = one-hot(addr) if addr < NUM_REGS; otherwise all-zero and the error flag is latched.
  - Write: go to DONE. Read: go to WAIT and load the counter with RD_LAT.
- WAIT:
  - o_cs=1 held, o_rs_vector=0.
  - Counter decrements each cycle. When it reaches 1, capture i_rdata (0 if error) and go to DONE.
- DONE (1 cycle):
  - o_ack[owner]=1, o_rdata and o_err valid, o_cs=1.
  - Pointer becomes ~owner. Go to RELEASE.
- RELEASE (1 cycle):
  - o_cs=0, o_ack=0. Go to IDLE.
  - o_cs therefore always returns low between accesses, so the downstream decoder re-arms.
- Latency from request seen in IDLE to ack: write = 2 cycles (GRANT, DONE); read = 2+RD_LAT.
- Minimum request-to-request period: write 4 cycles, read 4+RD_LAT.
- o_rdata and o_err hold their value until the next DONE; o_rdata is 0 after a write.
- Requests are sampled only in IDLE. Inputs changing after the latch have no effect.
- Dropping req mid-transaction does not abort; the ack is still issued.
- A requester still asserting req in the cycle after ack is treated as a new request.
- Simultaneous continuous requests alternate strictly, 0,1,0,1, starting from pointer 0 after reset.
- A write to an illegal address produces no select pulse, but o_cs still pulses and o_err=1 at ack.

Optional Feature:
CAN_ARB_FIXED_PRIO_EN
- Defined: requester 0 always wins simultaneous requests; the pointer is unused and held at 0. Requester 1 may starve.
- Undefined: round-robin as described above.
- Latencies are identical in both builds.

Test Plan:
- Reset, then req0 write of addr=5, wdata=0xA5 -> GRANT cycle: o_cs=1, o_r_neg_w=0, o_rs_vector=0x00000020, o_wdata=0xA5. Next cycle: o_ack=2'b01, o_err=0. Following cycle: o_cs=0.
- req1 read of addr=30, RD_LAT=2, i_rdata=0x3C -> o_rs_vector bit 30 pulses for one cycle. o_ack=2'b10 arrives 4 cycles after IDLE sampling, with o_rdata=0x3C.
- req0 and req1 held high continuously, 6 transactions -> ack order 0,1,0,1,0,1. With CAN_ARB_FIXED_PRIO_EN defined -> ack order 0,0,0,0,0,0.
- req0 read of addr=31 -> o_rs_vector stays 0 throughout; at ack o_err=1 and o_rdata=0x00.
- i_reset asserted during WAIT of a read -> all outputs 0 immediately, no ack. After release, a pending req1 is served first (pointer=0 but only req1 active).
- req0 dropped during GRANT -> ack still issued in DONE, then IDLE with o_busy=0.
